// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request/response and transmitter-handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
);
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*NB_WORD-1:0] i_word;
  logic [N_REQ-1:0]         o_ack;
  logic [N_REQ-1:0]         o_done;
  logic                     o_busy;
  logic                     o_tx_start;
  logic [NB_BYTE-1:0]       o_tx_byte;
  logic                     i_tx_done;
  modport slave (
    input  i_req, i_word, i_tx_done,
    output o_ack, o_done, o_busy, o_tx_start, o_tx_byte
  );
  modport master (
    output i_req, i_word, i_tx_done,
    input  o_ack, o_done, o_busy, o_tx_start, o_tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, one word per grant, LSB byte first.
// Define UART_TX_ARB_HEADER_EN to prefix each word with a header byte {4'hA, 1'b0, idx}.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
) (
  input  logic                clk,
  input  logic                i_reset_n,
  uart_tx_arbiter_if.slave    bus
);
  localparam int NB_BYTES = NB_WORD / NB_BYTE;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef UART_TX_ARB_HEADER_EN
  localparam int LAST = NB_BYTES;
`else
  localparam int LAST = NB_BYTES - 1;
`endif
  localparam int CW = (LAST > 0) ? $clog2(LAST + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_WORD-1:0] word_q, word_d;
  logic [NB_BYTE-1:0] tx_byte_q, tx_byte_d, sel;
  logic [IW-1:0]      cand, g;
  logic               found, load;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_comb begin
    found = 1'b0;
    g     = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (!found && bus.i_req[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = SEND;
        idx_d   = g;
        ptr_d   = (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
        cnt_d   = '0;
        word_d  = bus.i_word[int'(g)*NB_WORD +: NB_WORD];
        load    = 1'b1;
      end
      SEND: state_d = WAIT;
      WAIT: if (bus.i_tx_done) begin
        state_d = (cnt_q == CW'(LAST)) ? FINISH : SEND;
        cnt_d   = (cnt_q == CW'(LAST)) ? cnt_q : cnt_q + 1'b1;
        load    = cnt_q != CW'(LAST);
      end
      default: state_d = IDLE;
    endcase
    // the byte register is loaded on the way into SEND and then held through WAIT
`ifdef UART_TX_ARB_HEADER_EN
    sel = (cnt_d == '0) ? NB_BYTE'({4'hA, 1'b0, 3'(idx_d)})
                        : word_d[(int'(cnt_d) - 1)*NB_BYTE +: NB_BYTE];
`else
    sel = word_d[int'(cnt_d)*NB_BYTE +: NB_BYTE];
`endif
    tx_byte_d = load ? sel : tx_byte_q;
  end

  always_comb begin
    bus.o_busy     = state_q != IDLE;
    bus.o_tx_start = state_q == SEND;
    bus.o_ack      = (state_q == SEND && cnt_q == '0) ? N_REQ'(1) << idx_q : '0;
    bus.o_done     = (state_q == FINISH) ? N_REQ'(1) << idx_q : '0;
    bus.o_tx_byte  = tx_byte_q;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a round-robin byte-stream model.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  int mp;
  logic [31:0] words [4];

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4), .NB_WORD(32), .NB_BYTE(8)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .NB_WORD(32), .NB_BYTE(8)) dut (
    .clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return 0;
  endfunction

  task automatic set_word(input int k, input logic [31:0] w);
    words[k] = w;
    bus.i_word[k*32 +: 32] = w;
  endtask

  // One full frame: expected grant from the model pointer, then every byte with its handshake.
  task automatic xfer(input bit drop, input int gap, input bit spur);
    int k;
    int n;
    logic [31:0] w;
    logic [7:0] fr[$];
    k = rr_pick(mp, bus.i_req);
    n = 0;
    while (bus.o_ack == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ack", 64'(bus.o_ack), 64'(1) << k);
    if (drop) bus.i_req[k] = 1'b0;
    mp = (k + 1) % 4;
    w = words[k];
    set_word(k, $urandom);
    fr = {};
`ifdef UART_TX_ARB_HEADER_EN
    fr.push_back({4'hA, 1'b0, 3'(k)});
`endif
    for (int b = 0; b < 4; b++) fr.push_back(w[8*b +: 8]);
    foreach (fr[b]) begin
      chk("start", 64'({bus.o_tx_start, bus.o_tx_byte}), 64'({1'b1, fr[b]}));
      bus.i_tx_done = spur;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        chk("hold", 64'({bus.o_tx_start, bus.o_busy, bus.o_tx_byte}), 64'({2'b01, fr[b]}));
      end
      bus.i_tx_done = 1'b1;
      @(negedge clk);
      bus.i_tx_done = 1'b0;
    end
    chk("done", 64'(bus.o_done), 64'(1) << k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mp = 0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    bus.i_req = '0;
    bus.i_word = '0;
    bus.i_tx_done = 1'b0;
    rst_n = 1'b0;
    mp = 0;
    for (int k = 0; k < 4; k++) set_word(k, $urandom);
    repeat (2) @(negedge clk);
    chk("reset", 64'({bus.o_ack, bus.o_done, bus.o_tx_start, bus.o_busy, bus.o_tx_byte}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    set_word(0, 32'hDEADBEEF);
    bus.i_req = 4'b0001;
    xfer(1, 10, 0);
    @(negedge clk);
    chk("idle_after", 64'({bus.o_busy, bus.o_tx_start, bus.o_ack}), 64'(0));
    set_word(2, 32'h01020304);
    bus.i_req = 4'b0100;
    xfer(1, 3, 0);
    do_reset();
    bus.i_req = 4'b1111;
    for (int t = 0; t < 5; t++) xfer(0, $urandom_range(1, 4), 0);
    bus.i_req = '0;
    bus.i_req = 4'b1000;
    xfer(1, 2, 0);
    bus.i_req = 4'b1001;
    xfer(1, 2, 0);
    xfer(1, 2, 0);
    repeat (2) @(negedge clk);
    bus.i_tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_spur", 64'({bus.o_busy, bus.o_tx_start}), 64'(0));
    end
    bus.i_tx_done = 1'b0;
    bus.i_req = 4'b0010;
    xfer(1, 3, 1);
    for (int t = 0; t < 8; t++) begin
      if (bus.i_req == '0) bus.i_req = 4'($urandom_range(1, 15));
      xfer(1, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end
    while (bus.i_req != '0) xfer(1, 2, 0);
    repeat (2) @(negedge clk);
    bus.i_req = 4'b0001;
    n = 0;
    while (bus.o_ack == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_ack", 64'(bus.o_ack), 64'(1));
    bus.i_req = '0;
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    chk("mid_start2", 64'(bus.o_tx_start), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 64'({bus.o_ack, bus.o_done, bus.o_tx_start, bus.o_busy, bus.o_tx_byte}), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", 64'(bus.o_done), 64'(0));
    end
    rst_n = 1'b1;
    mp = 0;
    @(negedge clk);
    bus.i_req = 4'b1001;
    xfer(1, 2, 0);
    xfer(1, 2, 0);
    repeat (2) @(negedge clk);
    chk("final_idle", 64'(bus.o_busy), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing the single UART transmitter among N_REQ requesters (debug unit, register dump, status reporter).
- Each request is one NB_WORD word, serialized LSB-byte-first into one UART byte per transfer.
- Drives the transmitter through its start/done handshake and reports per-requester accept and completion pulses.
- Sits between the debug/control logic and the uart wrapper's i_debug2Tx / tx_start / o_txDone ports.

Parameters:
- N_REQ, 4, number of requesters; 2..8.
- NB_WORD, 32, bits per request word; must be a multiple of NB_BYTE.
- NB_BYTE, 8, UART byte width; NB_BYTES = NB_WORD/NB_BYTE bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_req  input  N_REQ  level request, one bit per requester; held until o_ack.
- i_word  input  N_REQ*NB_WORD  flattened words; requester k at bits [k*NB_WORD +: NB_WORD].
- o_ack  output  N_REQ  one-cycle one-hot pulse: word of requester k captured.
- o_done  output  N_REQ  one-cycle one-hot pulse: last byte of requester k's word transmitted.
- o_busy  output  1  high whenever state != IDLE.
- o_tx_start  output  1  one-cycle start pulse to the UART transmitter.
- o_tx_byte  output  NB_BYTE  byte to transmit; stable from the start pulse until the matching done.
- i_tx_done  input  1  transmitter done pulse.

Behaviour:
- Reset (async, active-low):
  - State IDLE; outputs o_ack, o_done, o_tx_start, o_busy = 0 and o_tx_byte = 0.
  - Round-robin pointer = 0; byte counter = 0; word register = 0.
  - Reset mid-transfer abandons the word with no o_done.
- States: IDLE, SEND, WAIT, FINISH.
- IDLE, when any i_req bit is set:
  - Grant the first set bit searching from pointer upward, with wrap-around.
  - Capture that requester's word and its index; pulse o_ack for the granted bit on the next cycle.
  - Pointer := granted index + 1 (mod N_REQ); byte counter := 0; go to SEND.
  - Requester sees o_ack exactly 1 cycle after the edge at which it was granted. It drops i_req on that edge; a req still high the cycle after o_ack is treated as a new request.
- SEND:
  - o_tx_start = 1 for exactly one cycle.
  - o_tx_byte = captured word byte[byte counter], with byte 0 = bits [7:0].
  - Go to WAIT.
- WAIT:
  - Hold o_tx_byte. On i_tx_done: if counter == NB_BYTES-1, go to FINISH; else counter += 1 and go to SEND.
  - The inter-byte gap is therefore 1 cycle after each done.
- FINISH:
  - Pulse o_done for the captured index for one cycle; go to IDLE.
  - A new grant can occur on the next cycle, so there are 2 cycles between done and the next o_ack.
- i_tx_done outside WAIT is ignored. i_tx_done in the same cycle as o_tx_start is ignored; only WAIT samples it.
- i_req and i_word changes after capture do not affect the word in flight.
- Simultaneous requests are served one word each in round-robin order; no requester is starved.
- No timeout: a missing i_tx_done holds WAIT indefinitely, with o_busy high.

Optional Feature:
- Macro UART_TX_ARB_HEADER_EN.
- Defined:
  - Each word is preceded by a header byte {4'hA, 1'b0, idx[2:0]}, sent through the same SEND/WAIT handshake.
  - Frame = NB_BYTES+1 UART bytes.
  - o_done still fires only after the last data byte.
- Undefined: no header; frame = NB_BYTES bytes; header logic absent.

Test Plan:
- Single request: i_req=4'b0001, word0=32'hDEADBEEF, done returned 10 cycles after each start.
  - o_ack=0001 once.
  - Bytes EF, BE, AD, DE in order, with 4 o_tx_start pulses.
  - o_done=0001 after the 4th done; o_busy then low.
- Simultaneous: i_req=4'b1111 held after reset.
  - Grant order 0,1,2,3,0,…
  - Each word's 4 bytes are contiguous, with no interleaving between requesters.
- Wrap fairness: after serving req 3, i_req=4'b1001 → requester 0 is granted before 3.
- Handshake robustness:
  - Spurious i_tx_done pulses in IDLE and SEND produce no counter advance and no extra o_tx_start.
  - o_tx_byte stays stable throughout WAIT.
- Reset mid-word: assert i_reset_n=0 after the 2nd byte's start.
  - All outputs go to 0 immediately; no o_done.
  - After release, a new request starts at byte 0 with pointer 0.
- With UART_TX_ARB_HEADER_EN: requester 2 sends 32'h01020304 → bytes A2, 04, 03, 02, 01, then o_done=0100.
